// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-master RAM arbiter/controller.
// Default sizes, master count, master-id type and tag helpers.
package ram_ctrl_pkg;

    localparam int RAM_WIDTH_DEF  = 64;
    localparam int ADDR_SIZE_DEF  = 12;
    localparam int RD_LATENCY_DEF = 1;
    localparam int NUM_MASTERS    = 2;

    typedef logic mid_t;

    typedef struct packed {
        logic vld;
        mid_t id;
    } rd_tag_t;

    function automatic logic [NUM_MASTERS-1:0] mid_onehot(input mid_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic mid_t onehot_mid(input logic [NUM_MASTERS-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/ram_arb_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// The pointer names the master that wins the next contention.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    mid_t ptr_q;
    mid_t ptr_d;

    // Lone requester wins at once; on contention the pointer decides.
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = mid_onehot(ptr_q);
        end
    end

    // Only an issued grant moves priority to the other master.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            ptr_d = ~onehot_mid(gnt_o);
        end
    end

    // Pointer register; reset gives master 0 the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arb_ctrl.sv
// Two-master arbiter and controller for a dual-port RAM.
// Independent write/read round-robin, collision hold, tagged reads.
module ram_arb_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_MASTERS-1:0]                m_wr_req,
    input  logic [NUM_MASTERS-1:0][ADDR_SIZE-1:0] m_wr_addr,
    input  logic [NUM_MASTERS-1:0][RAM_WIDTH-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]                m_wr_gnt,
    input  logic [NUM_MASTERS-1:0]                m_rd_req,
    input  logic [NUM_MASTERS-1:0][ADDR_SIZE-1:0] m_rd_addr,
    output logic [NUM_MASTERS-1:0]                m_rd_gnt,
    output logic [NUM_MASTERS-1:0]                m_rd_valid,
    output logic [RAM_WIDTH-1:0]                  m_rd_data,
    output logic [RAM_WIDTH-1:0]                  ram_data_in,
    output logic [ADDR_SIZE-1:0]                  ram_wr_address,
    output logic                                  ram_write,
    output logic [ADDR_SIZE-1:0]                  ram_rd_address,
    output logic                                  ram_read,
    input  logic [RAM_WIDTH-1:0]                  ram_data_out
);

    logic [1:0] wr_win;
    logic [1:0] rd_win;
    logic [1:0] rd_req_eff;
    logic [1:0] wr_gnt;
    logic [1:0] rd_gnt;
    mid_t       wr_id;
    mid_t       rd_id;
    logic       collide;

    logic       hold_q;
    logic       hold_d;
    mid_t       hold_id_q;
    mid_t       hold_id_d;

    logic                 ram_write_q;
    logic [ADDR_SIZE-1:0] ram_wr_address_q;
    logic [RAM_WIDTH-1:0] ram_data_in_q;
    logic                 ram_read_q;
    logic [ADDR_SIZE-1:0] ram_rd_address_q;

    rd_tag_t              tag_q [RD_LATENCY+1];
    logic [1:0]           rd_valid_q;
    logic [RAM_WIDTH-1:0] rd_data_q;

    // A withheld reader is the only read candidate on the following cycle.
    always_comb begin
        rd_req_eff = m_rd_req;
        if (hold_q) begin
            rd_req_eff = m_rd_req & mid_onehot(hold_id_q);
        end
    end

    rr_arb2 u_wr_arb (
        .clk       (clock),
        .rst       (reset),
        .req_i     (m_wr_req),
        .advance_i (|wr_gnt),
        .gnt_o     (wr_win)
    );

    rr_arb2 u_rd_arb (
        .clk       (clock),
        .rst       (reset),
        .req_i     (rd_req_eff),
        .advance_i (|rd_gnt),
        .gnt_o     (rd_win)
    );

    assign wr_id   = onehot_mid(wr_win);
    assign rd_id   = onehot_mid(rd_win);
    assign collide = (|wr_win) && (|rd_win) &&
                     (m_wr_addr[wr_id] == m_rd_addr[rd_id]);

    // Same-address conflict: normally the read yields to the write;
    // on the retry cycle the held read goes first and the write waits.
    always_comb begin
        wr_gnt = wr_win;
        rd_gnt = rd_win;
        if (reset) begin
            wr_gnt = 2'b00;
            rd_gnt = 2'b00;
        end else if (collide) begin
            if (hold_q) begin
                wr_gnt = 2'b00;
            end else begin
                rd_gnt = 2'b00;
            end
        end
    end

    // Remember which reader lost to a colliding write.
    always_comb begin
        hold_d    = 1'b0;
        hold_id_d = hold_id_q;
        if (!reset && collide && !hold_q) begin
            hold_d    = 1'b1;
            hold_id_d = rd_id;
        end
    end

    // Collision hold state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q    <= 1'b0;
            hold_id_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
        end
    end

    // Write port: strobe for one cycle, address/data hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_write_q      <= 1'b0;
            ram_wr_address_q <= '0;
            ram_data_in_q    <= '0;
        end else begin
            ram_write_q <= |wr_gnt;
            if (|wr_gnt) begin
                ram_wr_address_q <= m_wr_addr[wr_id];
                ram_data_in_q    <= m_wr_data[wr_id];
            end
        end
    end

    // Read port: strobe for one cycle, address holds when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_read_q       <= 1'b0;
            ram_rd_address_q <= '0;
        end else begin
            ram_read_q <= |rd_gnt;
            if (|rd_gnt) begin
                ram_rd_address_q <= m_rd_addr[rd_id];
            end
        end
    end

    // Master-id tags travel alongside the RAM access latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{vld: |rd_gnt, id: rd_id};
            for (int i = 1; i <= RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Capture RAM data with its tag and pulse the owner's valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 2'b00;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 2'b00;
            if (tag_q[RD_LATENCY].vld) begin
                rd_valid_q <= mid_onehot(tag_q[RD_LATENCY].id);
                rd_data_q  <= ram_data_out;
            end
        end
    end

    assign m_wr_gnt       = wr_gnt;
    assign m_rd_gnt       = rd_gnt;
    assign m_rd_valid     = rd_valid_q;
    assign m_rd_data      = rd_data_q;
    assign ram_write      = ram_write_q;
    assign ram_wr_address = ram_wr_address_q;
    assign ram_data_in    = ram_data_in_q;
    assign ram_read       = ram_read_q;
    assign ram_rd_address = ram_rd_address_q;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Self-checking bench for ram_arb_ctrl with a RAM model and
// a scoreboard of expected RAM strobes and read responses.
module tb_ram_arb_ctrl;

    localparam int W   = 64;
    localparam int A   = 12;
    localparam int RDL = 1;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         m_wr_req = '0;
    logic [1:0][A-1:0]  m_wr_addr = '0;
    logic [1:0][W-1:0]  m_wr_data = '0;
    logic [1:0]         m_wr_gnt;
    logic [1:0]         m_rd_req = '0;
    logic [1:0][A-1:0]  m_rd_addr = '0;
    logic [1:0]         m_rd_gnt;
    logic [1:0]         m_rd_valid;
    logic [W-1:0]       m_rd_data;
    logic [W-1:0]       ram_data_in;
    logic [A-1:0]       ram_wr_address;
    logic               ram_write;
    logic [A-1:0]       ram_rd_address;
    logic               ram_read;
    logic [W-1:0]       ram_data_out = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] mem     [0:4095];
    logic [W-1:0] ref_mem [0:4095];

    typedef struct { int due; logic [A-1:0] addr; logic [W-1:0] data; } wexp_t;
    typedef struct { int due; logic [A-1:0] addr; } aexp_t;
    typedef struct { int due; logic id; logic [W-1:0] data; } rexp_t;

    wexp_t wq[$];
    aexp_t aq[$];
    rexp_t rq[$];

    ram_arb_ctrl #(.RAM_WIDTH(W), .ADDR_SIZE(A), .RD_LATENCY(RDL)) dut (
        .clock          (clock),
        .reset          (reset),
        .m_wr_req       (m_wr_req),
        .m_wr_addr      (m_wr_addr),
        .m_wr_data      (m_wr_data),
        .m_wr_gnt       (m_wr_gnt),
        .m_rd_req       (m_rd_req),
        .m_rd_addr      (m_rd_addr),
        .m_rd_gnt       (m_rd_gnt),
        .m_rd_valid     (m_rd_valid),
        .m_rd_data      (m_rd_data),
        .ram_data_in    (ram_data_in),
        .ram_wr_address (ram_wr_address),
        .ram_write      (ram_write),
        .ram_rd_address (ram_rd_address),
        .ram_read       (ram_read),
        .ram_data_out   (ram_data_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
    end

    // Single-cycle dual-port RAM, old data on same-edge read/write.
    always @(posedge clock) begin
        if (ram_write) mem[ram_wr_address] <= ram_data_in;
        if (ram_read) ram_data_out <= mem[ram_rd_address];
    end

    // Scoreboard: push on grants, pop when the DUT should respond.
    always @(negedge clock) begin : mon
        logic  wi;
        logic  ri;
        wexp_t we;
        aexp_t ae;
        rexp_t re;
        if (reset) begin
            wq.delete();
            aq.delete();
            rq.delete();
        end else begin
            if (m_wr_gnt != 2'b00) begin
                checks++;
                if ($countones(m_wr_gnt) != 1 || (m_wr_gnt & ~m_wr_req) != 2'b00) begin
                    errors++;
                    $display("FAIL wr_gnt_legal gnt=%b req=%b", m_wr_gnt, m_wr_req);
                end
                wi = m_wr_gnt[1];
                ref_mem[m_wr_addr[wi]] = m_wr_data[wi];
                wq.push_back('{due: cyc + 1, addr: m_wr_addr[wi], data: m_wr_data[wi]});
            end
            if (m_rd_gnt != 2'b00) begin
                checks++;
                if ($countones(m_rd_gnt) != 1 || (m_rd_gnt & ~m_rd_req) != 2'b00) begin
                    errors++;
                    $display("FAIL rd_gnt_legal gnt=%b req=%b", m_rd_gnt, m_rd_req);
                end
                ri = m_rd_gnt[1];
                aq.push_back('{due: cyc + 1, addr: m_rd_addr[ri]});
                rq.push_back('{due: cyc + 2 + RDL, id: ri, data: ref_mem[m_rd_addr[ri]]});
            end
            checks++;
            if (wq.size() > 0 && wq[0].due == cyc) begin
                we = wq.pop_front();
                if (ram_write !== 1'b1 || ram_wr_address !== we.addr || ram_data_in !== we.data) begin
                    errors++;
                    $display("FAIL ram_wr got we=%b a=%h d=%h want a=%h d=%h",
                             ram_write, ram_wr_address, ram_data_in, we.addr, we.data);
                end
            end else if (ram_write !== 1'b0) begin
                errors++;
                $display("FAIL ram_wr_spurious got %b want 0", ram_write);
            end
            checks++;
            if (aq.size() > 0 && aq[0].due == cyc) begin
                ae = aq.pop_front();
                if (ram_read !== 1'b1 || ram_rd_address !== ae.addr) begin
                    errors++;
                    $display("FAIL ram_rd got re=%b a=%h want a=%h", ram_read, ram_rd_address, ae.addr);
                end
            end else if (ram_read !== 1'b0) begin
                errors++;
                $display("FAIL ram_rd_spurious got %b want 0", ram_read);
            end
            checks++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                re = rq.pop_front();
                if (m_rd_valid !== (re.id ? 2'b10 : 2'b01) || m_rd_data !== re.data) begin
                    errors++;
                    $display("FAIL rd_resp got v=%b d=%h want id=%0d d=%h",
                             m_rd_valid, m_rd_data, re.id, re.data);
                end
            end else if (m_rd_valid !== 2'b00) begin
                errors++;
                $display("FAIL rd_valid_spurious got %b want 00", m_rd_valid);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m_wr_req = 2'b11;
        m_rd_req = 2'b11;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (m_wr_gnt !== 2'b00) begin errors++; $display("FAIL rst_wr_gnt got %b want 00", m_wr_gnt); end
        checks++; if (m_rd_gnt !== 2'b00) begin errors++; $display("FAIL rst_rd_gnt got %b want 00", m_rd_gnt); end
        checks++; if (m_rd_valid !== 2'b00) begin errors++; $display("FAIL rst_rd_valid got %b want 00", m_rd_valid); end
        checks++; if (m_rd_data !== '0) begin errors++; $display("FAIL rst_rd_data got %h want 0", m_rd_data); end
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL rst_ram_write got %b want 0", ram_write); end
        checks++; if (ram_read !== 1'b0) begin errors++; $display("FAIL rst_ram_read got %b want 0", ram_read); end
        checks++; if (ram_wr_address !== '0) begin errors++; $display("FAIL rst_wr_addr got %h want 0", ram_wr_address); end
        checks++; if (ram_rd_address !== '0) begin errors++; $display("FAIL rst_rd_addr got %h want 0", ram_rd_address); end
        checks++; if (ram_data_in !== '0) begin errors++; $display("FAIL rst_data_in got %h want 0", ram_data_in); end
        m_wr_req = 2'b00;
        m_rd_req = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_contention;
        logic [1:0] want;
        m_wr_addr[0] = 12'h100;
        m_wr_addr[1] = 12'h101;
        m_wr_data[0] = 64'h0;
        m_wr_data[1] = 64'h1;
        m_wr_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clock);
            checks++;
            if (m_wr_gnt !== want) begin
                errors++;
                $display("FAIL contention_%0d got %b want %b", i, m_wr_gnt, want);
            end
            tick();
            m_wr_addr[i % 2] = m_wr_addr[i % 2] + 12'h2;
            m_wr_data[i % 2] = m_wr_data[i % 2] + 64'h2;
        end
        m_wr_req = 2'b00;
        tick();
    endtask

    task automatic test_lone_write;
        m_wr_addr[0] = 12'h005;
        m_wr_data[0] = 64'hDEAD_BEEF_0000_0001;
        m_wr_req = 2'b01;
        @(negedge clock);
        checks++;
        if (m_wr_gnt !== 2'b01) begin errors++; $display("FAIL lone_wr_gnt got %b want 01", m_wr_gnt); end
        tick();
        m_wr_req = 2'b00;
        @(negedge clock);
        checks++;
        if (ram_write !== 1'b1 || ram_wr_address !== 12'h005 || ram_data_in !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL lone_wr_ram got we=%b a=%h d=%h want 1 005 deadbeef00000001",
                     ram_write, ram_wr_address, ram_data_in);
        end
        tick();
    endtask

    task automatic test_read_latency;
        logic [1:0] want;
        m_rd_addr[1] = 12'h005;
        m_rd_req = 2'b10;
        @(negedge clock);
        checks++;
        if (m_rd_gnt !== 2'b10) begin errors++; $display("FAIL lat_rd_gnt got %b want 10", m_rd_gnt); end
        tick();
        m_rd_req = 2'b00;
        @(negedge clock);
        checks++;
        if (ram_read !== 1'b1 || ram_rd_address !== 12'h005) begin
            errors++;
            $display("FAIL lat_ram_read got re=%b a=%h want 1 005", ram_read, ram_rd_address);
        end
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) @(negedge clock);
            want = (j == 3) ? 2'b10 : 2'b00;
            checks++;
            if (m_rd_valid !== want) begin
                errors++;
                $display("FAIL lat_valid_k+%0d got %b want %b", j, m_rd_valid, want);
            end
            if (j == 3) begin
                checks++;
                if (m_rd_data !== 64'hDEAD_BEEF_0000_0001) begin
                    errors++;
                    $display("FAIL lat_data got %h want deadbeef00000001", m_rd_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_collision;
        bit found;
        m_wr_addr[0] = 12'h0AA;
        m_wr_data[0] = 64'h1234;
        m_rd_addr[1] = 12'h0AA;
        m_wr_req = 2'b01;
        m_rd_req = 2'b10;
        @(negedge clock);
        checks++;
        if (m_wr_gnt !== 2'b01 || m_rd_gnt !== 2'b00) begin
            errors++;
            $display("FAIL coll_first got wr=%b rd=%b want 01 00", m_wr_gnt, m_rd_gnt);
        end
        tick();
        m_wr_req = 2'b00;
        @(negedge clock);
        checks++;
        if (m_rd_gnt !== 2'b10) begin errors++; $display("FAIL coll_retry got %b want 10", m_rd_gnt); end
        tick();
        m_rd_req = 2'b00;
        found = 1'b0;
        for (int j = 0; j < 6 && !found; j++) begin
            @(negedge clock);
            if (m_rd_valid[1]) begin
                found = 1'b1;
                checks++;
                if (m_rd_data !== 64'h1234) begin
                    errors++;
                    $display("FAIL coll_data got %h want 1234", m_rd_data);
                end
            end
            tick();
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL coll_timeout got no valid want pulse");
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back;
        logic [1:0] vlog [10];
        logic [1:0] want;
        m_rd_addr[0] = 12'h005;
        m_rd_addr[1] = 12'h0AA;
        for (int j = 0; j < 10; j++) begin
            m_rd_req = (j < 6) ? ((j % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            @(negedge clock);
            vlog[j] = m_rd_valid;
            if (j < 6) begin
                checks++;
                if (m_rd_gnt !== m_rd_req) begin
                    errors++;
                    $display("FAIL b2b_gnt_%0d got %b want %b", j, m_rd_gnt, m_rd_req);
                end
            end
            tick();
        end
        for (int j = 0; j < 10; j++) begin
            want = (j >= 3 && j <= 8) ? ((j % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            checks++;
            if (vlog[j] !== want) begin
                errors++;
                $display("FAIL b2b_valid_%0d got %b want %b", j, vlog[j], want);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        m_rd_addr[0] = 12'h005;
        m_rd_req = 2'b01;
        @(negedge clock);
        checks++;
        if (m_rd_gnt !== 2'b01) begin errors++; $display("FAIL rmid_gnt got %b want 01", m_rd_gnt); end
        tick();
        m_rd_req = 2'b00;
        reset = 1'b1;
        tick();
        @(negedge clock);
        checks++;
        if (m_rd_valid !== 2'b00 || ram_read !== 1'b0 || ram_write !== 1'b0 ||
            m_rd_data !== '0 || ram_rd_address !== '0 || ram_wr_address !== '0 ||
            ram_data_in !== '0 || m_wr_gnt !== 2'b00 || m_rd_gnt !== 2'b00) begin
            errors++;
            $display("FAIL rmid_outputs got v=%b re=%b we=%b d=%h want all 0",
                     m_rd_valid, ram_read, ram_write, m_rd_data);
        end
        tick();
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            checks++;
            if (m_rd_valid !== 2'b00) begin
                errors++;
                $display("FAIL rmid_valid_%0d got %b want 00", j, m_rd_valid);
            end
            tick();
        end
    endtask

    task automatic test_random;
        logic [1:0] wp;
        logic [1:0] rp;
        logic [1:0] gw;
        logic [1:0] gr;
        wp = 2'b00;
        rp = 2'b00;
        for (int n = 0; n < 300; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!wp[m] && $urandom_range(0, 1) == 1) begin
                    wp[m] = 1'b1;
                    m_wr_addr[m] = 12'($urandom_range(0, 7));
                    m_wr_data[m] = {$urandom(), $urandom()};
                end
                if (!rp[m] && $urandom_range(0, 1) == 1) begin
                    rp[m] = 1'b1;
                    m_rd_addr[m] = 12'($urandom_range(0, 7));
                end
            end
            m_wr_req = wp;
            m_rd_req = rp;
            @(negedge clock);
            gw = m_wr_gnt;
            gr = m_rd_gnt;
            tick();
            wp = wp & ~gw;
            rp = rp & ~gr;
        end
        m_wr_req = 2'b00;
        m_rd_req = 2'b00;
        repeat (8) tick();
        checks++;
        if (rq.size() != 0 || wq.size() != 0 || aq.size() != 0) begin
            errors++;
            $display("FAIL rand_drain got rq=%0d wq=%0d aq=%0d want 0",
                     rq.size(), wq.size(), aq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_lone_write();
        test_read_latency();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
